voice_allocator: RTL and testbench
==================================

Name: voice_allocator

Overview:
- Polyphony scheduler in front of NV notebank voices.
- Accepts note-on/note-off events over a valid/ready handshake and assigns each note-on to a voice: retrigger, else free, else steal.
- Drives per-voice note_on/note_off pulses and period registers, and frees voices when their amplitude envelope reports done.
- Sits between the event decoder and the notebank array, in the clk_slow domain.

Parameters:
- NV, 4, number of notebank voices (2..16).
- KEY_W, 7, key number width.
- PER_W, 32, period word width, matching the notebank period input.
- AGE_W, 8, per-voice age counter width; saturating.

Ports:
- clk_slow  input  1  system sample-rate clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ev_valid  input  1  event present.
- ev_ready  output  1  allocator can accept an event.
- ev_on  input  1  1 = note-on, 0 = note-off.
- ev_key  input  KEY_W  key number.
- ev_period  input  PER_W  oscillator period for note-on; ignored for note-off.
- voice_done  input  NV  per-voice amplitude-envelope done level.
- voice_note_on  output  NV  one-cycle note_on pulse per voice.
- voice_note_off  output  NV  one-cycle note_off pulse per voice.
- voice_period  output  NV*PER_W  registered period per voice; voice i occupies bits [i*PER_W +: PER_W].
- steal  output  1  one-cycle pulse when a note-on displaced an active voice.
- active_cnt  output  $clog2(NV+1)  number of voices not FREE.

Behaviour:
- Reset values: all voices FREE; key and period registers 0; ages saturated at max; ev_ready=1; all pulses, steal and active_cnt 0. Reset mid-operation aborts any in-flight event with no pulse issued.
- Per-voice state: FREE, HELD, RELEASE.
- Control FSM: IDLE -> SELECT -> ISSUE -> IDLE.
  - Acceptance occurs in the IDLE cycle T when ev_valid & ev_ready. Event fields are latched and ev_ready drops at T+1.
  - SELECT (T+1): compute the target voice.
  - ISSUE (T+2): pulse outputs are registered, visible at T+2. ev_ready returns at T+3.
  - Throughput: one event per 3 cycles.
- Note-on target priority, first match wins:
  - (1) HELD or RELEASE voice with the same key (retrigger, no steal);
  - (2) lowest-index FREE voice;
  - (3) RELEASE voice with the largest age;
  - (4) HELD voice with the largest age.
  - Age ties resolve to the lowest index.
- Note-on effects on the target: key and period written; state becomes HELD; age cleared to 0. Every other voice's age increments, saturating at 2^AGE_W-1. steal=1 for cases (3) and (4).
- Note-off: the lowest-index HELD voice with matching key gets note_off pulsed and moves to RELEASE. With no match, the event is consumed silently and no pulse is issued. Ages are unchanged.
- Voice release: a RELEASE voice with voice_done=1 becomes FREE on the next edge. voice_done while HELD or FREE is ignored.
- Collision: if voice_done frees a voice in the same cycle ISSUE writes it, ISSUE wins and the voice ends HELD.
- voice_period changes only in the ISSUE cycle for the target voice; it is stable otherwise.
- active_cnt is registered and updates one cycle after any state change.

Decomposition:
- Shared package (synth_pkg): voice state encodings (FREE=0, HELD=1, RELEASE=2), FSM state encodings, and defaults for NV, PER_W and KEY_W, shared with the notebank array top.
- One sub-module, voice_select: combinational priority and oldest-age search over NV voices. It outputs the target index and steal flag, isolating the comparator tree from the sequencing logic.

Test Plan:
- Reset, then note-on key=60, period=1000 accepted at T -> voice_note_on=4'b0001 at T+2, voice_period[0]=1000, ev_ready low at T+1..T+2, active_cnt=1 at T+3.
- Four note-ons (keys 60,62,64,65), then a fifth (key 67) -> voices 0..3 filled in order; fifth steals voice 0 (largest age): steal=1, voice_note_on=4'b0001, key[0]=67.
- Note-off key=62 -> voice_note_off=4'b0010 at T+2. Then assert voice_done[1] -> voice 1 FREE next cycle, and the next note-on lands on voice 1.
- All voices HELD, voice 2 in RELEASE, then note-on -> voice 2 chosen over older HELD voices; steal=1.
- Note-on key=60 while voice 0 holds key 60 -> retrigger voice 0, steal=0, active_cnt unchanged. Note-off key=99 with no match -> no pulses, ev_ready returns at T+3.
- Assert rst during SELECT -> outputs at reset values immediately, no note_on pulse; ev_ready=1 after release.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared encodings and default sizes for the synth voice path (allocator and notebank array).
package synth_pkg;

  localparam int NV_DEF    = 4;
  localparam int KEY_W_DEF = 7;
  localparam int PER_W_DEF = 32;
  localparam int AGE_W_DEF = 8;
  localparam int VS_W      = 2;

  typedef enum logic [VS_W-1:0] {
    V_FREE = 2'd0,
    V_HELD = 2'd1,
    V_REL  = 2'd2
  } vstate_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SELECT = 2'd1,
    S_ISSUE  = 2'd2
  } fsm_e;

  function automatic logic vs_busy(input logic [VS_W-1:0] s);
    return s != V_FREE;
  endfunction

endpackage

// File: rtl/voice_select.sv
// Combinational target search: retrigger, else lowest free, else oldest release, else oldest held.
// For note-off it returns the lowest-index held voice with the matching key.
module voice_select
  import synth_pkg::*;
#(
  parameter int NV    = NV_DEF,
  parameter int KEY_W = KEY_W_DEF,
  parameter int AGE_W = AGE_W_DEF,
  parameter int IW    = $clog2(NV)
) (
  input  logic [NV-1:0][VS_W-1:0]  vst_i,
  input  logic [NV-1:0][KEY_W-1:0] key_i,
  input  logic [NV-1:0][AGE_W-1:0] age_i,
  input  logic                     ev_on_i,
  input  logic [KEY_W-1:0]         ev_key_i,
  output logic [IW-1:0]            idx_o,
  output logic                     hit_o,
  output logic                     steal_o
);

  logic            rt_hit, fr_hit, rl_hit, hd_hit, off_hit;
  logic [IW-1:0]   rt_idx, fr_idx, rl_idx, hd_idx, off_idx;
  logic [AGE_W-1:0] rl_age, hd_age;

  always_comb begin
    rt_hit  = 1'b0; rt_idx  = '0;
    fr_hit  = 1'b0; fr_idx  = '0;
    off_hit = 1'b0; off_idx = '0;
    rl_hit  = 1'b0; rl_idx  = '0; rl_age = '0;
    hd_hit  = 1'b0; hd_idx  = '0; hd_age = '0;
    // Walk downward so the last match written is the lowest index.
    for (int i = NV-1; i >= 0; i--) begin
      if (vs_busy(vst_i[i]) && key_i[i] == ev_key_i) begin
        rt_hit = 1'b1; rt_idx = IW'(i);
      end
      if (vst_i[i] == V_FREE) begin
        fr_hit = 1'b1; fr_idx = IW'(i);
      end
      if (vst_i[i] == V_HELD && key_i[i] == ev_key_i) begin
        off_hit = 1'b1; off_idx = IW'(i);
      end
    end
    // Strict compare walking upward keeps age ties on the lowest index.
    for (int i = 0; i < NV; i++) begin
      if (vst_i[i] == V_REL && (!rl_hit || age_i[i] > rl_age)) begin
        rl_hit = 1'b1; rl_idx = IW'(i); rl_age = age_i[i];
      end
      if (vst_i[i] == V_HELD && (!hd_hit || age_i[i] > hd_age)) begin
        hd_hit = 1'b1; hd_idx = IW'(i); hd_age = age_i[i];
      end
    end
  end

  always_comb begin
    idx_o   = '0;
    hit_o   = 1'b0;
    steal_o = 1'b0;
    if (!ev_on_i) begin
      hit_o = off_hit;
      idx_o = off_idx;
    end else if (rt_hit) begin
      hit_o = 1'b1; idx_o = rt_idx;
    end else if (fr_hit) begin
      hit_o = 1'b1; idx_o = fr_idx;
    end else if (rl_hit) begin
      hit_o = 1'b1; idx_o = rl_idx; steal_o = 1'b1;
    end else if (hd_hit) begin
      hit_o = 1'b1; idx_o = hd_idx; steal_o = 1'b1;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphony scheduler: accepts note events, picks a voice, pulses note_on/note_off and owns per-voice period.
// Target choice and all voice writes commit on the SELECT->ISSUE edge, so pulses are visible during ISSUE.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NV    = NV_DEF,
  parameter int KEY_W = KEY_W_DEF,
  parameter int PER_W = PER_W_DEF,
  parameter int AGE_W = AGE_W_DEF
) (
  input  logic                     clk_slow,
  input  logic                     rst,
  input  logic                     ev_valid,
  output logic                     ev_ready,
  input  logic                     ev_on,
  input  logic [KEY_W-1:0]         ev_key,
  input  logic [PER_W-1:0]         ev_period,
  input  logic [NV-1:0]            voice_done,
  output logic [NV-1:0]            voice_note_on,
  output logic [NV-1:0]            voice_note_off,
  output logic [NV*PER_W-1:0]      voice_period,
  output logic                     steal,
  output logic [$clog2(NV+1)-1:0]  active_cnt
);

  localparam int IW = $clog2(NV);
  localparam int CW = $clog2(NV+1);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  fsm_e                     fsm_q, fsm_d;
  logic [NV-1:0][VS_W-1:0]  vst_q, vst_d;
  logic [NV-1:0][KEY_W-1:0] key_q, key_d;
  logic [NV-1:0][PER_W-1:0] per_q, per_d;
  logic [NV-1:0][AGE_W-1:0] age_q, age_d;
  logic [NV-1:0]            non_q, non_d, noff_q, noff_d;
  logic                     steal_q, steal_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     ev_on_q, ev_on_d;
  logic [KEY_W-1:0]         ev_key_q, ev_key_d;
  logic [PER_W-1:0]         ev_per_q, ev_per_d;

  logic          accept;
  logic [IW-1:0] sel_idx;
  logic          sel_hit, sel_steal;

  assign ev_ready       = (fsm_q == S_IDLE);
  assign accept         = ev_valid & ev_ready;
  assign voice_note_on  = non_q;
  assign voice_note_off = noff_q;
  assign voice_period   = per_q;
  assign steal          = steal_q;
  assign active_cnt     = cnt_q;

  voice_select #(
    .NV   (NV),
    .KEY_W(KEY_W),
    .AGE_W(AGE_W),
    .IW   (IW)
  ) u_sel (
    .vst_i   (vst_q),
    .key_i   (key_q),
    .age_i   (age_q),
    .ev_on_i (ev_on_q),
    .ev_key_i(ev_key_q),
    .idx_o   (sel_idx),
    .hit_o   (sel_hit),
    .steal_o (sel_steal)
  );

  always_comb begin
    fsm_d    = fsm_q;
    vst_d    = vst_q;
    key_d    = key_q;
    per_d    = per_q;
    age_d    = age_q;
    non_d    = '0;
    noff_d   = '0;
    steal_d  = 1'b0;
    ev_on_d  = ev_on_q;
    ev_key_d = ev_key_q;
    ev_per_d = ev_per_q;

    for (int i = 0; i < NV; i++) begin
      if (vst_q[i] == V_REL && voice_done[i]) vst_d[i] = V_FREE;
    end

    unique case (fsm_q)
      S_IDLE: begin
        if (accept) begin
          fsm_d    = S_SELECT;
          ev_on_d  = ev_on;
          ev_key_d = ev_key;
          ev_per_d = ev_period;
        end
      end
      S_SELECT: begin
        fsm_d = S_ISSUE;
        // Written after the release loop so a same-cycle done cannot free the target.
        if (ev_on_q && sel_hit) begin
          for (int i = 0; i < NV; i++) begin
            age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + 1'b1;
          end
          age_d[sel_idx] = '0;
          key_d[sel_idx] = ev_key_q;
          per_d[sel_idx] = ev_per_q;
          vst_d[sel_idx] = V_HELD;
          non_d[sel_idx] = 1'b1;
          steal_d        = sel_steal;
        end else if (!ev_on_q && sel_hit) begin
          vst_d[sel_idx]  = V_REL;
          noff_d[sel_idx] = 1'b1;
        end
      end
      S_ISSUE: fsm_d = S_IDLE;
      default: fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < NV; i++) begin
      if (vs_busy(vst_q[i])) cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk_slow or posedge rst) begin
    if (rst) begin
      fsm_q    <= S_IDLE;
      vst_q    <= '0;
      key_q    <= '0;
      per_q    <= '0;
      age_q    <= '1;
      non_q    <= '0;
      noff_q   <= '0;
      steal_q  <= 1'b0;
      cnt_q    <= '0;
      ev_on_q  <= 1'b0;
      ev_key_q <= '0;
      ev_per_q <= '0;
    end else begin
      fsm_q    <= fsm_d;
      vst_q    <= vst_d;
      key_q    <= key_d;
      per_q    <= per_d;
      age_q    <= age_d;
      non_q    <= non_d;
      noff_q   <= noff_d;
      steal_q  <= steal_d;
      cnt_q    <= cnt_d;
      ev_on_q  <= ev_on_d;
      ev_key_q <= ev_key_d;
      ev_per_q <= ev_per_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: driver queues hand-computed responses, negedge monitor checks them.
module tb_voice_allocator;

  localparam int NV = 4;

  logic             clk_slow = 1'b0;
  logic             rst;
  logic             ev_valid;
  logic             ev_ready;
  logic             ev_on;
  logic [6:0]       ev_key;
  logic [31:0]      ev_period;
  logic [NV-1:0]    voice_done;
  logic [NV-1:0]    voice_note_on;
  logic [NV-1:0]    voice_note_off;
  logic [NV*32-1:0] voice_period;
  logic             steal;
  logic [2:0]       active_cnt;

  typedef struct {
    logic [NV-1:0] on;
    logic [NV-1:0] off;
    logic          st;
    logic [31:0]   per;
    int            cnt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad   = 0;
  int   ph    = 0;

  voice_allocator dut (
    .clk_slow      (clk_slow),
    .rst           (rst),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_on         (ev_on),
    .ev_key        (ev_key),
    .ev_period     (ev_period),
    .voice_done    (voice_done),
    .voice_note_on (voice_note_on),
    .voice_note_off(voice_note_off),
    .voice_period  (voice_period),
    .steal         (steal),
    .active_cnt    (active_cnt)
  );

  always #5 clk_slow = ~clk_slow;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: ph tracks T+1 (SELECT), T+2 (ISSUE), T+3 (back in IDLE) after an observed acceptance.
  always @(negedge clk_slow) begin
    if (rst) begin
      ph = 0;
    end else begin
      case (ph)
        0: begin
          chk("idle_quiet", 128'({voice_note_on, voice_note_off, steal}), 128'(0));
          if (ev_valid && ev_ready) ph = 1;
        end
        1: begin
          chk("ready_low_select", 128'(ev_ready), 128'(0));
          ph = 2;
        end
        2: begin
          chk("ready_low_issue", 128'(ev_ready), 128'(0));
          total++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_underflow: got response with empty queue expected queued entry");
            ph = 0;
          end else begin
            cur = sb.pop_front();
            chk("note_on", 128'(voice_note_on), 128'(cur.on));
            chk("note_off", 128'(voice_note_off), 128'(cur.off));
            chk("steal", 128'(steal), 128'(cur.st));
            for (int i = 0; i < NV; i++) begin
              if (cur.on[i]) chk("period", 128'(voice_period[i*32 +: 32]), 128'(cur.per));
            end
            ph = 3;
          end
        end
        default: begin
          chk("ready_back", 128'(ev_ready), 128'(1));
          chk("active_cnt", 128'(active_cnt), 128'(cur.cnt));
          ph = (ev_valid && ev_ready) ? 1 : 0;
        end
      endcase
    end
  end

  task automatic send(input bit on, input int key, input int per,
                      input logic [NV-1:0] eon, input logic [NV-1:0] eoff, input bit est,
                      input int ecnt, input logic [NV-1:0] dsel, input bit do_rst);
    exp_t e;
    int   n;
    n = 0;
    while (!ev_ready && n < 20) begin
      @(posedge clk_slow); #1;
      n++;
    end
    chk("ready_wait", 128'(ev_ready), 128'(1));
    if (!ev_ready) return;
    ev_on     = on;
    ev_key    = 7'(key);
    ev_period = 32'(per);
    ev_valid  = 1'b1;
    if (!do_rst) begin
      e.on = eon; e.off = eoff; e.st = est; e.per = 32'(per); e.cnt = ecnt;
      sb.push_back(e);
    end
    @(posedge clk_slow); #1;
    ev_valid   = 1'b0;
    voice_done = dsel;
    if (do_rst) begin
      rst = 1'b1;
      #1;
      chk("rst_note_on", 128'(voice_note_on), 128'(0));
      chk("rst_ready", 128'(ev_ready), 128'(1));
      chk("rst_cnt", 128'(active_cnt), 128'(0));
      chk("rst_period", 128'(voice_period), 128'(0));
      @(posedge clk_slow); #1;
      @(posedge clk_slow); #1;
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk_slow); #1;
        chk("post_rst_no_pulse", 128'({voice_note_on, steal}), 128'(0));
      end
      chk("post_rst_ready", 128'(ev_ready), 128'(1));
    end else begin
      @(posedge clk_slow); #1;
      voice_done = '0;
    end
  endtask

  initial begin
    int n;
    rst = 1'b1; ev_valid = 1'b0; ev_on = 1'b0; ev_key = '0; ev_period = '0; voice_done = '0;
    repeat (3) @(posedge clk_slow);
    #1;
    chk("reset_ready", 128'(ev_ready), 128'(1));
    chk("reset_cnt", 128'(active_cnt), 128'(0));
    chk("reset_pulses", 128'({voice_note_on, voice_note_off, steal}), 128'(0));
    chk("reset_period", 128'(voice_period), 128'(0));
    rst = 1'b0;
    @(posedge clk_slow); #1;

    // Fill voices 0..3 in order, then steal the oldest held voice (0).
    send(1, 60, 1000, 4'b0001, 4'b0000, 0, 1, 4'b0, 0);
    send(1, 62, 2000, 4'b0010, 4'b0000, 0, 2, 4'b0, 0);
    send(1, 64, 3000, 4'b0100, 4'b0000, 0, 3, 4'b0, 0);
    send(1, 65, 4000, 4'b1000, 4'b0000, 0, 4, 4'b0, 0);
    send(1, 67, 5000, 4'b0001, 4'b0000, 1, 4, 4'b0, 0);
    // Release voice 1, let its envelope finish, then reuse it as a free voice.
    send(0, 62, 0, 4'b0000, 4'b0010, 0, 4, 4'b0, 0);
    @(posedge clk_slow); #1; voice_done = 4'b0010;
    @(posedge clk_slow); #1; voice_done = 4'b0000;
    @(posedge clk_slow); #1;
    chk("cnt_after_done", 128'(active_cnt), 128'(3));
    send(1, 69, 6000, 4'b0010, 4'b0000, 0, 4, 4'b0, 0);
    // Releasing voice is preferred over older held voices.
    send(0, 64, 0, 4'b0000, 4'b0100, 0, 4, 4'b0, 0);
    send(1, 71, 7000, 4'b0100, 4'b0000, 1, 4, 4'b0, 0);
    // Retrigger of a held voice and of a releasing voice: no steal.
    send(1, 67, 1234, 4'b0001, 4'b0000, 0, 4, 4'b0, 0);
    send(0, 65, 0, 4'b0000, 4'b1000, 0, 4, 4'b0, 0);
    send(1, 65, 999, 4'b1000, 4'b0000, 0, 4, 4'b0, 0);
    // Note-off without a matching key is consumed silently.
    send(0, 99, 0, 4'b0000, 4'b0000, 0, 4, 4'b0, 0);
    // Envelope done during SELECT on the chosen releasing voice: the note-on wins.
    send(0, 69, 0, 4'b0000, 4'b0010, 0, 4, 4'b0, 0);
    send(1, 80, 4242, 4'b0010, 4'b0000, 1, 4, 4'b0010, 0);
    // Reset while the event is in SELECT, then a clean note-on.
    send(1, 90, 5555, 4'b0000, 4'b0000, 0, 0, 4'b0, 1);
    send(1, 60, 1000, 4'b0001, 4'b0000, 0, 1, 4'b0, 0);
    chk("period_vec_after_rst", 128'(voice_period), 128'(1000));

    n = 0;
    while ((sb.size() != 0 || ph != 0) && n < 20) begin
      @(posedge clk_slow); #1;
      n++;
    end
    chk("sb_drained", 128'(sb.size()), 128'(0));
    chk("monitor_idle", 128'(ph), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
